// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite to native register bus responder:
// response codes, FSM state encoding and the default native-access timeout.
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_ACCESS = 3'd1,
        ST_WR_RESP   = 3'd2,
        ST_RD_ACCESS = 3'd3,
        ST_RD_RESP   = 3'd4
    } axil_state_e;

endpackage

// File: rtl/axil_native_slave.sv
// AXI4-Lite responder driving a single-outstanding native valid/ready register bus.
// Optional native-access timeout (SLVERR on expiry) enabled by AXIL_NATIVE_TIMEOUT_EN.
module axil_native_slave
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(3);

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~LOW_MASK;
    endfunction

    axil_state_e           state_r, state_s;
    logic                  aw_full_r, aw_full_s, w_full_r, w_full_s;
    logic                  last_was_read_r, last_was_read_s;
    logic [ADDR_WIDTH-1:0] aw_addr_r, aw_addr_s;
    logic [31:0]           w_data_r, w_data_s;
    logic [3:0]            w_strb_r, w_strb_s;
    logic                  awready_r, awready_s, wready_r, wready_s, arready_r, arready_s;
    logic                  mem_valid_r, mem_valid_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]           mem_wdata_r, mem_wdata_s;
    logic [3:0]            mem_wstrb_r, mem_wstrb_s;
    logic                  bvalid_r, bvalid_s, rvalid_r, rvalid_s;
    logic [1:0]            bresp_r, bresp_s, rresp_r, rresp_s;
    logic [31:0]           rdata_r, rdata_s;
    logic                  aw_hs_s, w_hs_s, ar_hs_s;
    logic                  timeout_s, access_done_s;
    logic [1:0]            access_resp_s;

`ifdef AXIL_NATIVE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_r;

    // Access-duration counter; zero whenever the FSM is outside an access state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if (state_r == ST_WR_ACCESS || state_r == ST_RD_ACCESS) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == ST_WR_ACCESS || state_r == ST_RD_ACCESS) &&
                       (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // A completion that arrives together with expiry still counts as a normal completion.
    assign access_done_s = mem_ready || timeout_s;
    assign access_resp_s = mem_ready ? AXI_RESP_OKAY : AXI_RESP_SLVERR;

    // Next-state and next-output logic for the whole responder.
    always_comb begin
        state_s         = state_r;
        aw_full_s       = aw_full_r;
        w_full_s        = w_full_r;
        last_was_read_s = last_was_read_r;
        aw_addr_s       = aw_addr_r;
        w_data_s        = w_data_r;
        w_strb_s        = w_strb_r;
        mem_valid_s     = mem_valid_r;
        mem_addr_s      = mem_addr_r;
        mem_wdata_s     = mem_wdata_r;
        mem_wstrb_s     = mem_wstrb_r;
        bvalid_s        = bvalid_r;
        bresp_s         = bresp_r;
        rvalid_s        = rvalid_r;
        rresp_s         = rresp_r;
        rdata_s         = rdata_r;
        aw_hs_s         = s_awvalid && awready_r;
        w_hs_s          = s_wvalid && wready_r;
        ar_hs_s         = s_arvalid && arready_r;

        case (state_r)
            ST_IDLE: begin
                if (aw_hs_s) begin
                    aw_full_s = 1'b1;
                    aw_addr_s = s_awaddr;
                end else begin
                    aw_full_s = aw_full_r;
                end
                if (w_hs_s) begin
                    w_full_s = 1'b1;
                    w_data_s = s_wdata;
                    w_strb_s = s_wstrb;
                end else begin
                    w_full_s = w_full_r;
                end
                // A read accepted this cycle beats a write pair that is only now completing.
                if (ar_hs_s) begin
                    state_s         = ST_RD_ACCESS;
                    last_was_read_s = 1'b1;
                    mem_valid_s     = 1'b1;
                    mem_addr_s      = word_align(s_araddr);
                    mem_wstrb_s     = 4'b0000;
                end else if (aw_full_r && w_full_r) begin
                    aw_full_s       = 1'b0;
                    w_full_s        = 1'b0;
                    last_was_read_s = 1'b0;
                    mem_addr_s      = word_align(aw_addr_r);
                    mem_wdata_s     = w_data_r;
                    if (w_strb_r == 4'b0000) begin
                        state_s  = ST_WR_RESP;
                        bvalid_s = 1'b1;
                        bresp_s  = AXI_RESP_OKAY;
                    end else begin
                        state_s     = ST_WR_ACCESS;
                        mem_valid_s = 1'b1;
                        mem_wstrb_s = w_strb_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_ACCESS: begin
                if (access_done_s) begin
                    state_s     = ST_WR_RESP;
                    mem_valid_s = 1'b0;
                    mem_wstrb_s = 4'b0000;
                    bvalid_s    = 1'b1;
                    bresp_s     = access_resp_s;
                end else begin
                    state_s = ST_WR_ACCESS;
                end
            end
            ST_WR_RESP: begin
                if (s_bready) begin
                    state_s  = ST_IDLE;
                    bvalid_s = 1'b0;
                end else begin
                    state_s = ST_WR_RESP;
                end
            end
            ST_RD_ACCESS: begin
                if (access_done_s) begin
                    state_s     = ST_RD_RESP;
                    mem_valid_s = 1'b0;
                    rvalid_s    = 1'b1;
                    rresp_s     = access_resp_s;
                    rdata_s     = mem_ready ? mem_rdata : 32'h0000_0000;
                end else begin
                    state_s = ST_RD_ACCESS;
                end
            end
            ST_RD_RESP: begin
                if (s_rready) begin
                    state_s  = ST_IDLE;
                    rvalid_s = 1'b0;
                end else begin
                    state_s = ST_RD_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                mem_valid_s = 1'b0;
                bvalid_s    = 1'b0;
                rvalid_s    = 1'b0;
            end
        endcase

        // Readies are registered copies of what next-cycle state implies, so no valid-to-ready path.
        awready_s = (state_s == ST_IDLE) && !aw_full_s;
        wready_s  = (state_s == ST_IDLE) && !w_full_s;
        arready_s = (state_s == ST_IDLE) && !(aw_full_s && w_full_s && last_was_read_s);
    end

    // State and output registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            aw_full_r       <= 1'b0;
            w_full_r        <= 1'b0;
            last_was_read_r <= 1'b0;
            aw_addr_r       <= '0;
            w_data_r        <= 32'h0000_0000;
            w_strb_r        <= 4'b0000;
            awready_r       <= 1'b0;
            wready_r        <= 1'b0;
            arready_r       <= 1'b0;
            mem_valid_r     <= 1'b0;
            mem_addr_r      <= '0;
            mem_wdata_r     <= 32'h0000_0000;
            mem_wstrb_r     <= 4'b0000;
            bvalid_r        <= 1'b0;
            bresp_r         <= 2'b00;
            rvalid_r        <= 1'b0;
            rresp_r         <= 2'b00;
            rdata_r         <= 32'h0000_0000;
        end else begin
            state_r         <= state_s;
            aw_full_r       <= aw_full_s;
            w_full_r        <= w_full_s;
            last_was_read_r <= last_was_read_s;
            aw_addr_r       <= aw_addr_s;
            w_data_r        <= w_data_s;
            w_strb_r        <= w_strb_s;
            awready_r       <= awready_s;
            wready_r        <= wready_s;
            arready_r       <= arready_s;
            mem_valid_r     <= mem_valid_s;
            mem_addr_r      <= mem_addr_s;
            mem_wdata_r     <= mem_wdata_s;
            mem_wstrb_r     <= mem_wstrb_s;
            bvalid_r        <= bvalid_s;
            bresp_r         <= bresp_s;
            rvalid_r        <= rvalid_s;
            rresp_r         <= rresp_s;
            rdata_r         <= rdata_s;
        end
    end

    assign s_awready = awready_r;
    assign s_wready  = wready_r;
    assign s_arready = arready_r;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_rvalid  = rvalid_r;
    assign s_rresp   = rresp_r;
    assign s_rdata   = rdata_r;
    assign mem_valid = mem_valid_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;

endmodule
